// File: rtl/mux_select_bank_pkg.sv
// -----------------------------------------------------------------------------
// mux_select_pkg
// Shared constants for the registered selector bank (mux_select_bank).
//
// Contents:
//   SEL211_W / SEL414_W / SEL811_W   select widths of the three lanes
//   DATA211_W / DATA414_W / DATA811_W candidate bus widths of the three lanes
//   OUT414_W                         width of one 414-lane element / result
//   ELEM211_W / ELEM811_W            element widths of the single-bit lanes
//   N211 / N414 / N811               number of candidates per lane
//
// Every lane has a power-of-two candidate count, so each select width is
// exactly log2 of the candidate count and every select code is meaningful.
// -----------------------------------------------------------------------------
package mux_select_pkg;

    // Select widths.
    localparam int SEL211_W  = 1;
    localparam int SEL414_W  = 2;
    localparam int SEL811_W  = 3;

    // Candidate bus widths.
    localparam int DATA211_W = 2;
    localparam int DATA414_W = 16;
    localparam int DATA811_W = 8;

    // 414-lane element (nibble) width.
    localparam int OUT414_W  = 4;

    // Element widths of the single-bit lanes.
    localparam int ELEM211_W = 1;
    localparam int ELEM811_W = 1;

    // Candidate counts, derived from the select widths.
    localparam int N211      = 1 << SEL211_W;
    localparam int N414      = 1 << SEL414_W;
    localparam int N811      = 1 << SEL811_W;

endpackage : mux_select_pkg

// File: rtl/mux_select_bank_if.sv
// -----------------------------------------------------------------------------
// mux_select_bank_if
// Bundles the capture enable, the three lanes' candidate/select inputs and the
// three registered results of mux_select_bank.
//
// Parameters:
//   W414_ELEM  width of one 414-lane element; the 414 candidate bus is
//              4*W414_ELEM bits wide and the 414 result is W414_ELEM bits.
//
// Signals:
//   inEn        capture enable common to all lanes
//   inData211   2 candidates of 1 bit, bit i = element i
//   inSel211    1-bit select
//   outData211  registered 211 result
//   inData414   4 candidates of W414_ELEM bits, element i = [W*i +: W]
//   inSel414    2-bit select
//   outData414  registered 414 result
//   inData811   8 candidates of 1 bit, bit i = element i
//   inSel811    3-bit select
//   outData811  registered 811 result
//
// Modports:
//   master  the side that drives candidates/selects and reads results
//   slave   the selector bank itself
// -----------------------------------------------------------------------------
interface mux_select_bank_if
    import mux_select_pkg::*;
#(
    parameter int W414_ELEM = OUT414_W
);

    logic                       inEn;

    logic [DATA211_W-1:0]       inData211;
    logic [SEL211_W-1:0]        inSel211;
    logic                       outData211;

    logic [N414*W414_ELEM-1:0]  inData414;
    logic [SEL414_W-1:0]        inSel414;
    logic [W414_ELEM-1:0]       outData414;

    logic [DATA811_W-1:0]       inData811;
    logic [SEL811_W-1:0]        inSel811;
    logic                       outData811;

    modport master (
        output inEn,
        output inData211, inSel211,
        output inData414, inSel414,
        output inData811, inSel811,
        input  outData211, outData414, outData811
    );

    modport slave (
        input  inEn,
        input  inData211, inSel211,
        input  inData414, inSel414,
        input  inData811, inSel811,
        output outData211, outData414, outData811
    );

endinterface : mux_select_bank_if

// File: rtl/mux_select_bank_sel_reg.sv
// -----------------------------------------------------------------------------
// mux_sel_reg
// Generic registered N:1 selector. Picks element inSel out of a packed bus of
// N_ELEM elements (element 0 in the least significant bits) and registers it.
//
// Parameters:
//   ELEM_W     width of one element
//   N_ELEM     number of elements; must be a power of two (>= 2) so that
//              every select code addresses a real element
//   RESET_VAL  bit replicated across the output on reset
//
// Ports:
//   inClk    in   1                clock, rising edge
//   inRst    in   1                asynchronous active-high reset
//   inEn     in   1                capture enable
//   inData   in   ELEM_W*N_ELEM    packed candidates
//   inSel    in   log2(N_ELEM)     unsigned element index
//   outData  out  ELEM_W           registered selected element
// -----------------------------------------------------------------------------
module mux_sel_reg #(
    parameter int ELEM_W    = 1,
    parameter int N_ELEM    = 2,
    parameter bit RESET_VAL = 1'b0,
    localparam int SEL_W    = $clog2(N_ELEM)
) (
    input  logic                     inClk,
    input  logic                     inRst,
    input  logic                     inEn,
    input  logic [ELEM_W*N_ELEM-1:0] inData,
    input  logic [SEL_W-1:0]         inSel,
    output logic [ELEM_W-1:0]        outData
);

    // Unpacked view of the candidate bus. Slicing with a constant genvar base
    // keeps the variable index down to exactly SEL_W bits, which is the full
    // address range because N_ELEM is a power of two.
    logic [ELEM_W-1:0] elemArr [N_ELEM];

    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
        assign elemArr[gi] = inData[gi*ELEM_W +: ELEM_W];
    end

    logic [ELEM_W-1:0] picked;

    always_comb begin
        picked = elemArr[inSel];
    end

    // Output register: the only path from inputs to outData, so there is no
    // combinational input-to-output path and the latency is exactly one edge.
    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            outData <= {ELEM_W{RESET_VAL}};
        end else if (inEn) begin
            outData <= picked;
        end
    end

endmodule : mux_sel_reg

// File: rtl/mux_select_bank.sv
// -----------------------------------------------------------------------------
// mux_select_bank
// Registered bank of three independent selectors sharing clock, reset and
// capture enable:
//   211 lane: 2:1 bit selector      outData211 <= inData211[inSel211]
//   414 lane: 4:1 element selector  outData414 <= inData414[W*inSel414 +: W]
//             (a multiplexer, despite the legacy DEMUX414 name)
//   811 lane: 8:1 bit selector      outData811 <= inData811[inSel811]
//
// Parameters:
//   W414_ELEM  width of one 414-lane element (default 4, a nibble)
//   RESET_VAL  bit replicated into every output register on reset
//
// Ports:
//   inClk  in  1   clock, all registers update on the rising edge
//   inRst  in  1   asynchronous active-high reset; outputs forced to
//                  RESET_VAL at once and held while high
//   bus    mux_select_bank_if.slave
//                  enable, candidates, selects and registered results
//
// The lanes share no state; each is its own mux_sel_reg instance. When inEn
// is low at an edge all three results hold.
// -----------------------------------------------------------------------------
module mux_select_bank
    import mux_select_pkg::*;
#(
    parameter int W414_ELEM = OUT414_W,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic                  inClk,
    input  logic                  inRst,
    mux_select_bank_if.slave      bus
);

    // 211 lane: 2 candidates of 1 bit.
    mux_sel_reg #(
        .ELEM_W    (ELEM211_W),
        .N_ELEM    (N211),
        .RESET_VAL (RESET_VAL)
    ) u_lane211 (
        .inClk   (inClk),
        .inRst   (inRst),
        .inEn    (bus.inEn),
        .inData  (bus.inData211),
        .inSel   (bus.inSel211),
        .outData (bus.outData211)
    );

    // 414 lane: 4 candidates of W414_ELEM bits.
    mux_sel_reg #(
        .ELEM_W    (W414_ELEM),
        .N_ELEM    (N414),
        .RESET_VAL (RESET_VAL)
    ) u_lane414 (
        .inClk   (inClk),
        .inRst   (inRst),
        .inEn    (bus.inEn),
        .inData  (bus.inData414),
        .inSel   (bus.inSel414),
        .outData (bus.outData414)
    );

    // 811 lane: 8 candidates of 1 bit.
    mux_sel_reg #(
        .ELEM_W    (ELEM811_W),
        .N_ELEM    (N811),
        .RESET_VAL (RESET_VAL)
    ) u_lane811 (
        .inClk   (inClk),
        .inRst   (inRst),
        .inEn    (bus.inEn),
        .inData  (bus.inData811),
        .inSel   (bus.inSel811),
        .outData (bus.outData811)
    );

endmodule : mux_select_bank

// File: tb/tb_mux_select_bank.sv
// -----------------------------------------------------------------------------
// tb_mux_select_bank
// Directed and randomized checks of mux_select_bank against a behavioural
// model. The model computes each lane's expected result by shifting the
// candidate word right by (select * element width) and masking one element,
// updating only on edges where reset is low and the enable is high.
// -----------------------------------------------------------------------------
module tb_mux_select_bank;
    import mux_select_pkg::*;

    logic inClk;
    logic inRst;

    int total;
    int bad;

    // Model state: expected registered results.
    logic       exp211;
    logic [3:0] exp414;
    logic       exp811;

    mux_select_bank_if #(.W414_ELEM(4)) bus ();

    mux_select_bank #(
        .W414_ELEM (4),
        .RESET_VAL (1'b0)
    ) dut (
        .inClk (inClk),
        .inRst (inRst),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    // ---------------- model ----------------
    function automatic logic [3:0] model414(logic [15:0] d, logic [1:0] s);
        logic [15:0] shifted;
        shifted = d >> (4 * int'(s));
        return shifted[3:0];
    endfunction

    function automatic logic model_bit(logic [7:0] d, int s);
        logic [7:0] shifted;
        shifted = d >> s;
        return shifted[0];
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out211"}, {3'b000, bus.outData211}, {3'b000, exp211});
        chk({tag, ".out414"}, bus.outData414, exp414);
        chk({tag, ".out811"}, {3'b000, bus.outData811}, {3'b000, exp811});
    endtask

    // One rising edge: advance the model from the inputs seen at the edge,
    // then sample the DUT 1 time unit later.
    task automatic step(input string tag);
        @(posedge inClk);
        if (inRst) begin
            exp211 = 1'b0;
            exp414 = 4'h0;
            exp811 = 1'b0;
        end else if (bus.inEn) begin
            exp211 = model_bit({6'b0, bus.inData211}, int'(bus.inSel211));
            exp414 = model414(bus.inData414, bus.inSel414);
            exp811 = model_bit(bus.inData811, int'(bus.inSel811));
        end
        #1;
        chk_all(tag);
    endtask

    // Reset raised between edges: outputs must clear without a clock.
    task automatic async_reset(input string tag);
        inRst = 1'b1;
        #1;
        exp211 = 1'b0;
        exp414 = 4'h0;
        exp811 = 1'b0;
        chk_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       hold414_v;
        logic [3:0] held414;
        logic       held811;

        total = 0;
        bad   = 0;
        exp211 = 1'b0;
        exp414 = 4'h0;
        exp811 = 1'b0;

        inRst         = 1'b0;
        bus.inEn      = 1'b1;
        bus.inData211 = '0;
        bus.inSel211  = '0;
        bus.inData414 = 16'hFFFF;
        bus.inSel414  = 2'b11;
        bus.inData811 = '0;
        bus.inSel811  = '0;

        // 1. Reset before any clock edge, then held for 3 edges.
        #1;
        async_reset("rst_async_pre_edge");
        for (int i = 0; i < 3; i++) step("rst_held");
        inRst = 1'b0;
        step("rst_release");
        chk("rst_release_414F", bus.outData414, 4'hF);

        // 2. 414 nibble select.
        bus.inData414 = 16'h00B0; bus.inSel414 = 2'b01;
        step("s414_sel1");
        chk("s414_B", bus.outData414, 4'hB);
        bus.inSel414 = 2'b00;
        step("s414_sel0");
        chk("s414_0", bus.outData414, 4'h0);
        bus.inData414 = 16'hA000; bus.inSel414 = 2'b11;
        step("s414_sel3");
        chk("s414_A", bus.outData414, 4'hA);

        // 3. 811 sweep over every select code.
        bus.inData811 = 8'h20;
        for (int s = 0; s < N811; s++) begin
            bus.inSel811 = 3'(s);
            step("s811_sweep");
            chk("s811_sweep_const", {3'b000, bus.outData811}, (s == 5) ? 4'h1 : 4'h0);
        end

        // 4. 211 select.
        bus.inData211 = 2'b10; bus.inSel211 = 1'b0;
        step("s211_a");
        chk("s211_a_const", {3'b000, bus.outData211}, 4'h0);
        bus.inSel211 = 1'b1;
        step("s211_b");
        chk("s211_b_const", {3'b000, bus.outData211}, 4'h1);
        bus.inData211 = 2'b01;
        step("s211_c");
        chk("s211_c_const", {3'b000, bus.outData211}, 4'h0);

        // 5. Enable hold.
        bus.inData811 = 8'h01; bus.inSel811 = 3'b000;
        step("hold_capture");
        chk("hold_capture_const", {3'b000, bus.outData811}, 4'h1);
        bus.inEn = 1'b0;
        bus.inData811 = 8'h00;
        bus.inData414 = 16'h5555; bus.inSel414 = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step("hold_off");
            chk("hold_off_const", {3'b000, bus.outData811}, 4'h1);
        end
        bus.inEn = 1'b1;
        step("hold_resume");
        chk("hold_resume_const", {3'b000, bus.outData811}, 4'h0);

        // 6. Lane independence: toggle the 211 lane only.
        bus.inData414 = 16'h3C00; bus.inSel414 = 2'b10;
        bus.inData811 = 8'h80;    bus.inSel811 = 3'b111;
        step("indep_setup");
        held414 = 4'hC;
        held811 = 1'b1;
        hold414_v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.inData211 = 2'($urandom_range(0, 3));
            bus.inSel211  = ~bus.inSel211;
            step("indep_toggle");
            if (hold414_v) begin
                chk("indep_414", bus.outData414, held414);
                chk("indep_811", {3'b000, bus.outData811}, {3'b000, held811});
            end
        end

        // Simultaneous data + select change is indexed together.
        bus.inData414 = 16'h1234; bus.inSel414 = 2'b11;
        step("simul_change");
        chk("simul_414", bus.outData414, 4'h1);

        // Reset mid-operation discards state; capture resumes after release.
        async_reset("rst_mid_async");
        step("rst_mid_held");
        inRst = 1'b0;
        step("rst_mid_release");

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            bus.inEn      = ($urandom_range(0, 4) != 0);
            bus.inData211 = 2'($urandom);
            bus.inSel211  = 1'($urandom);
            bus.inData414 = 16'($urandom);
            bus.inSel414  = 2'($urandom);
            bus.inData811 = 8'($urandom);
            bus.inSel811  = 3'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_rst");
                step("rand_rst_held");
                inRst = 1'b0;
            end else begin
                step("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux_select_bank
